// File: rtl/par_serializer.sv
// par_serializer
//   Parallel-to-serial converter with one word of buffering. A word is
//   accepted into a holding register, then moved into a shift register
//   and sent one bit per clock. The holding register refills while the
//   shifter is busy, so consecutive words leave with no gap.
//
// Parameters
//   DATA_W     : parallel word width (2..64)
//   LSB_FIRST  : 0 = send pdata[DATA_W-1] first, 1 = send pdata[0] first
//   IDLE_LEVEL : sdata level whenever svalid is low
//
// Ports
//   clk     in   rising-edge clock
//   reset_n in   asynchronous active-low reset
//   pdata   in   parallel word, sampled only on accept
//   pvalid  in   pdata holds a word offered for transfer
//   pready  out  a word can be accepted this cycle (state only)
//   sdata   out  registered serial data
//   svalid  out  sdata carries a payload bit
//   sfirst  out  sdata is the first bit of a word
//   slast   out  sdata is the final bit of a word
//   busy    out  a word is held or being shifted
module par_serializer #(
    parameter int   DATA_W     = 16,
    parameter bit   LSB_FIRST  = 1'b0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] pdata,
    input  logic              pvalid,
    output logic              pready,
    output logic              sdata,
    output logic              svalid,
    output logic              sfirst,
    output logic              slast,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    // Explicit terminal count so widths that are not a power of two stop
    // at the right bit instead of relying on counter wrap.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state;
    logic              hold_full;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt;

    logic accept;
    logic at_last;
    logic load;

    // Bit that leaves first from a word in the configured order.
    function automatic logic lead_bit(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_W-1];
    endfunction

    // Word with its leading bit consumed.
    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    assign accept  = pvalid && !hold_full;
    assign at_last = (state == SHIFT) && (cnt == LAST_CNT);
    // The shifter takes the held word when idle or on its own last bit,
    // which is what removes the idle cycle between consecutive words.
    assign load    = hold_full && ((state == IDLE) || at_last);

    assign pready = !hold_full;
    assign svalid = (state == SHIFT);
    assign slast  = at_last;
    assign busy   = hold_full || (state == SHIFT);

    // Holding register payload; only meaningful while hold_full is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_q <= pdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            hold_full <= 1'b0;
            shift_q   <= '0;
            cnt       <= '0;
            sdata     <= IDLE_LEVEL;
            sfirst    <= 1'b0;
        end else begin
            // accept and load are exclusive: accept needs hold empty,
            // load needs hold full.
            if (load) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_full <= 1'b1;
            end

            if (load) begin
                state   <= SHIFT;
                sdata   <= lead_bit(hold_q);
                shift_q <= advance(hold_q);
                cnt     <= '0;
                sfirst  <= 1'b1;
            end else if (at_last) begin
                state  <= IDLE;
                sdata  <= IDLE_LEVEL;
                cnt    <= '0;
                sfirst <= 1'b0;
            end else if (state == SHIFT) begin
                sdata   <= lead_bit(shift_q);
                shift_q <= advance(shift_q);
                cnt     <= cnt + CNT_W'(1);
                sfirst  <= 1'b0;
            end
        end
    end

endmodule
